// File: rtl/approx_arb_pkg.sv
// approx_arb_pkg: shared width, operand type and output-slot state for the approximate-add arbiter.
package approx_arb_pkg;
  localparam int DATA_W = 40;
  typedef logic [DATA_W-1:0] operand_t;
  typedef enum logic {EMPTY, FULL} slot_t;
endpackage

// File: rtl/approx_adder_core.sv
// approx_adder_core: 40-bit adder, mirror-approximated low APPROX_BITS, exact upper part fed by their carry.
module approx_adder_core
  import approx_arb_pkg::*;
#(
  parameter int APPROX_BITS = 8
) (
  input  operand_t a,
  input  operand_t b,
  output operand_t sum
);
  logic [APPROX_BITS:0] c;
  operand_t lo, hi;
  assign c[0] = 1'b0;
  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    if (i < APPROX_BITS) begin : g_apx
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] | b[i]));
      assign lo[i]  = ~c[i+1];
    end else begin : g_exact
      assign lo[i] = 1'b0;
    end
  end
  // upper section is aligned to bit 0 so the add wraps naturally at 40 bits
  assign hi  = (a >> APPROX_BITS) + (b >> APPROX_BITS) + operand_t'(c[APPROX_BITS]);
  assign sum = lo | (hi << APPROX_BITS);
endmodule

// File: rtl/approx_add_arbiter.sv
// approx_add_arbiter: round-robin share of one approximate adder with a single registered result slot.
// Optional APPROX_ERR_CNT_EN adds a saturating count of accepted sums that differ from the exact sum.
module approx_add_arbiter
  import approx_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int APPROX_BITS = 8,
  localparam int IW         = $clog2(N_REQ)
) (
  input  logic                  clock,
  input  logic                  reset_L,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  operand_t [N_REQ-1:0]  req_a,
  input  operand_t [N_REQ-1:0]  req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IW-1:0]         rsp_id,
  output operand_t              rsp_sum
`ifdef APPROX_ERR_CNT_EN
  ,
  output logic [15:0]           err_cnt
`endif
);
  slot_t state;
  logic [IW-1:0] rr_ptr, win;
  logic any, free, accept;
  operand_t sum;
  // descending scan so the candidate closest above rr_ptr is the last one written
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
        win = IW'((int'(rr_ptr) + k) % N_REQ);
        any = 1'b1;
      end
  end
  assign free      = state == EMPTY || rsp_ready;
  assign accept    = reset_L && free && any;
  assign req_ready = accept ? N_REQ'(1) << win : '0;
  assign rsp_valid = state == FULL;
  approx_adder_core #(.APPROX_BITS(APPROX_BITS)) u_core (
    .a   (req_a[win]),
    .b   (req_b[win]),
    .sum (sum)
  );
  always_ff @(posedge clock or negedge reset_L)
    if (!reset_L) begin
      state   <= EMPTY;
      rsp_sum <= '0;
      rsp_id  <= '0;
      rr_ptr  <= '0;
    end else if (accept) begin
      state   <= FULL;
      rsp_sum <= sum;
      rsp_id  <= win;
      rr_ptr  <= win == IW'(N_REQ - 1) ? '0 : win + 1'b1;
    end else if (rsp_ready) state <= EMPTY;
`ifdef APPROX_ERR_CNT_EN
  operand_t exact;
  assign exact = req_a[win] + req_b[win];
  always_ff @(posedge clock or negedge reset_L)
    if (!reset_L) err_cnt <= '0;
    else if (accept && sum != exact && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_approx_add_arbiter.sv
// tb_approx_add_arbiter: vector table plus scoreboard against a bit-serial reference model.
module tb_approx_add_arbiter;
  localparam int N  = 4;
  localparam int AB = 8;
  typedef struct {logic [1:0] id; logic [39:0] sum;} exp_t;
  typedef struct {int r; logic [39:0] a; logic [39:0] b; logic [39:0] sum;} vec_t;
  logic clock = 1'b0, reset_L;
  logic [N-1:0] req_valid, req_ready;
  logic [N-1:0][39:0] req_a, req_b;
  logic rsp_valid, rsp_ready;
  logic [1:0] rsp_id;
  logic [39:0] rsp_sum;
`ifdef APPROX_ERR_CNT_EN
  logic [15:0] err_cnt;
  int m_err = 0;
`endif
  int checks = 0, errors = 0, m_rr = 0;
  logic m_valid = 1'b0;
  exp_t q[$];
  vec_t vt[6];
  approx_add_arbiter #(.N_REQ(N), .APPROX_BITS(AB)) dut (
    .clock(clock), .reset_L(reset_L), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum)
`ifdef APPROX_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [39:0] model_sum(input logic [39:0] a, input logic [39:0] b);
    logic [39:0] s;
    logic [1:0] t;
    logic c;
    s = '0;
    c = 1'b0;
    for (int i = 0; i < 40; i++) begin
      t = 2'(a[i]) + 2'(b[i]) + 2'(c);
      c = t[1];
      s[i] = i < AB ? ~t[1] : t[0];
    end
    return s;
  endfunction
  // one clock: check combinational ready and the slot against the model, then step
  task automatic cycle(input logic ov, input logic [39:0] ov_sum);
    logic [N-1:0] er;
    logic acc;
    int w;
    exp_t e;
    #1;
    er = '0;
    acc = 1'b0;
    w = 0;
    for (int k = N - 1; k >= 0; k--)
      if (req_valid[(m_rr + k) % N]) begin
        w = (m_rr + k) % N;
        acc = 1'b1;
      end
    acc = acc && (!m_valid || rsp_ready);
    if (acc) er[w] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
    if (m_valid) begin
      if (q.size() == 0) chk("scoreboard_empty", 64'(1), 64'(0));
      else begin
        chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
        chk("rsp_sum", 64'(rsp_sum), 64'(q[0].sum));
        if (rsp_ready) void'(q.pop_front());
      end
    end
    if (acc) begin
      e.id = 2'(w);
      e.sum = ov ? ov_sum : model_sum(req_a[w], req_b[w]);
      q.push_back(e);
      m_rr = (w + 1) % N;
      m_valid = 1'b1;
`ifdef APPROX_ERR_CNT_EN
      if (e.sum != req_a[w] + req_b[w] && m_err != 16'hFFFF) m_err++;
`endif
    end else if (rsp_ready) m_valid = 1'b0;
    @(posedge clock);
    #1;
`ifdef APPROX_ERR_CNT_EN
    chk("err_cnt", 64'(err_cnt), 64'(m_err));
`endif
  endtask
  initial begin
    vt[0] = '{0, 40'h01, 40'h01, 40'h00000000FE};
    vt[1] = '{1, 40'hFF, 40'hFF, 40'h0000000100};
    vt[2] = '{2, 40'h00, 40'h00, 40'h00000000FF};
    vt[3] = '{3, 40'h100, 40'h200, 40'h00000003FF};
    vt[4] = '{0, 40'hFFFFFFFFFF, 40'h01, 40'h0000000000};
    vt[5] = '{1, 40'h0F, 40'hF0, 40'h00000000FF};
    reset_L = 1'b0;
    req_valid = '1;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    #1;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset_rsp_sum", 64'(rsp_sum), 64'(0));
    chk("reset_rsp_id", 64'(rsp_id), 64'(0));
    chk("reset_req_ready", 64'(req_ready), 64'(0));
    repeat (2) @(posedge clock);
    req_valid = '0;
    @(negedge clock) reset_L = 1'b1;
    @(posedge clock);
    #1;
    // all requesters busy: rotation 0,1,2,3,0
    req_valid = '1;
    rsp_ready = 1'b1;
    repeat (5) cycle(1'b0, '0);
    req_valid = '0;
    cycle(1'b0, '0);
    for (int v = 0; v < 6; v++) begin
      req_valid = N'(1) << vt[v].r;
      req_a[vt[v].r] = vt[v].a;
      req_b[vt[v].r] = vt[v].b;
      cycle(1'b1, vt[v].sum);
    end
    req_valid = '0;
    cycle(1'b0, '0);
    // stall with req2 waiting, then drain and refill in one cycle
    req_valid = 4'b0001;
    req_a[0] = 40'h0F;
    req_b[0] = 40'hF0;
    rsp_ready = 1'b0;
    cycle(1'b1, 40'hFF);
    req_valid = 4'b0100;
    req_a[2] = 40'h01;
    req_b[2] = 40'h01;
    repeat (3) cycle(1'b0, '0);
    rsp_ready = 1'b1;
    cycle(1'b1, 40'hFE);
    req_valid = '0;
    cycle(1'b0, '0);
    // async reset drops a held result
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    cycle(1'b0, '0);
    req_valid = '1;
    reset_L = 1'b0;
    #1;
    chk("midreset_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("midreset_rsp_sum", 64'(rsp_sum), 64'(0));
    chk("midreset_req_ready", 64'(req_ready), 64'(0));
    q.delete();
    m_valid = 1'b0;
    m_rr = 0;
`ifdef APPROX_ERR_CNT_EN
    m_err = 0;
`endif
    req_valid = '0;
    @(negedge clock) reset_L = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 4'b1000;
    rsp_ready = 1'b1;
    cycle(1'b0, '0);
    req_valid = '1;
    cycle(1'b0, '0);
    req_valid = '0;
    cycle(1'b0, '0);
    repeat (300) begin
      req_valid = N'($urandom_range(0, 15));
      for (int r = 0; r < N; r++) begin
        req_a[r] = {8'($urandom), 32'($urandom)};
        req_b[r] = {8'($urandom), 32'($urandom)};
      end
      rsp_ready = 1'($urandom_range(0, 1));
      cycle(1'b0, '0);
    end
`ifdef APPROX_ERR_CNT_EN
    req_a = '0;
    req_b = '0;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    repeat (70000) cycle(1'b0, '0);
    chk("err_cnt_saturated", 64'(err_cnt), 64'hFFFF);
`endif
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (3) cycle(1'b0, '0);
    chk("scoreboard_drained", 64'(q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/approx_add_arbiter.md
APPROX_ADD_ARBITER -- requirements
Module: approx_add_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the adder; legal range 2..8.
REQ-002 Parameter APPROX_BITS, default 8: low-order bits computed with mirror approximation; legal range 0..39.
REQ-003 Port clock, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset_L, input, 1: reset is asynchronous and active-low.
REQ-005 Port req_valid, input, N_REQ: requester i presents an operand pair.
REQ-006 Port req_ready, output, N_REQ: requester i's pair is accepted this cycle.
REQ-007 Port req_a, input, N_REQ x 40: operand A per requester.
REQ-008 Port req_b, input, N_REQ x 40: operand B per requester.
REQ-009 Port rsp_valid, output, 1: result held in the output slot.
REQ-010 Port rsp_ready, input, 1: consumer takes the result this cycle.
REQ-011 Port rsp_id, output, $clog2(N_REQ): index of the requester owning the result.
REQ-012 Port rsp_sum, output, 40: approximate sum.

Function
REQ-013 The block SHALL compute bits [APPROX_BITS-1:0] per bit as cout = maj(a,b,cin) and sum = ~cout, with bit-0 carry-in 0.
REQ-014 The block SHALL compute bits [39:APPROX_BITS] as an exact add with carry-in equal to the approximate section's carry-out; the final carry-out is discarded (mod 2^40).
REQ-015 The output slot SHALL be free when rsp_valid=0 or when rsp_valid&rsp_ready in the same cycle (drain-and-refill allowed).
REQ-016 When the slot is free and any req_valid is set, exactly one req_ready bit SHALL be high: round-robin winner searching upward from pointer rr_ptr, with wrap from N_REQ-1 to 0.
REQ-017 req_ready SHALL be 0 for all requesters when the slot is not free; req_ready[i] SHALL never be high while req_valid[i] is low.
REQ-018 On acceptance, rsp_sum/rsp_id SHALL be registered and rsp_valid SHALL rise on the same edge (latency 1 cycle); rr_ptr SHALL become winner+1 mod N_REQ.
REQ-019 rsp_valid, rsp_sum and rsp_id SHALL hold stable while rsp_valid&~rsp_ready.
REQ-020 With no acceptance, a drain (rsp_valid&rsp_ready) SHALL clear rsp_valid on the next edge.
REQ-021 Sustained throughput SHALL be one result per cycle while rsp_ready=1.
REQ-022 Slot state machine: EMPTY->FULL on accept; FULL->FULL on drain+accept or on stall; FULL->EMPTY on drain without accept.

Reset
REQ-023 While reset_L=0: rsp_valid=0, rsp_sum=0, rsp_id=0, rr_ptr=0, req_ready=0, state EMPTY.
REQ-024 Reset asserted mid-operation SHALL discard any held result; no response is replayed after reset.

Configuration
REQ-025 With APPROX_ERR_CNT_EN defined: add output err_cnt (16 bits, reset 0), incremented on each acceptance whose approximate sum differs from the exact 40-bit sum, saturating at 0xFFFF.
REQ-026 Without APPROX_ERR_CNT_EN: no exact adder, no err_cnt port; all other behaviour identical.

Structure
REQ-027 Package approx_arb_pkg SHALL hold DATA_W=40, typedef operand_t (logic [39:0]), and the slot-state enum {EMPTY, FULL}.
REQ-028 Combinational datapath SHALL be sub-module approx_adder_core (params APPROX_BITS; ports a, b, sum); arbitration and slot logic stay in approx_add_arbiter.

Verification (N_REQ=4, APPROX_BITS=8)
REQ-029 req0 A=0x01, B=0x01, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_sum=0x00000000FE.
REQ-030 req1 A=0xFF, B=0xFF -> rsp_sum=0x0000000100, rsp_id=1; with macro, err_cnt increments 0->1.
REQ-031 All four req_valid held high, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0 on consecutive cycles.
REQ-032 rsp_ready=0 for 3 cycles with result 0xFF and req2 pending -> rsp_sum/rsp_id stable, req_ready=0; rsp_ready=1 -> drain and req2 accepted same cycle.
REQ-033 reset_L pulsed low while rsp_valid=1 -> rsp_valid=0 immediately; after release req3 first -> rsp_id=3 and rr_ptr=0.
REQ-034 A=0, B=0 -> rsp_sum=0x00000000FF; err_cnt saturates at 0xFFFF under 70000 such mismatches.
